// File: rtl/video_timing.sv
// Free-running video timing generator with a DVI/VGA output stage aligned to the controller's pixel latency.
// Optional feature macro: VIDEO_TIMING_FRAME_IRQ_EN adds the o_frame_irq output.

module video_timing #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter bit H_SYNC_POL    = 1'b0,
  parameter bit V_SYNC_POL    = 1'b0,
  parameter int PIXEL_LATENCY = 3
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_video_hblank,
  output logic        o_video_vblank,
  output logic [10:0] o_video_pos_x,
  output logic [10:0] o_video_pos_y,
  input  logic [31:0] i_video_rdata,
  output logic        o_dvi_hsync,
  output logic        o_dvi_vsync,
  output logic        o_dvi_de,
  output logic [23:0] o_dvi_rgb
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
  ,
  output logic        o_frame_irq
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS    = H_ACTIVE + H_FRONT;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_ACTIVE + V_FRONT;
  localparam int V_SE    = V_SS + V_SYNC;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("video_timing: H_TOTAL/V_TOTAL must not exceed 2048");
  end
  if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 8) begin : g_bad_latency
    $error("video_timing: PIXEL_LATENCY must be 1..8");
  end

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } tap_t;

  logic [10:0] r_hcount, r_vcount;
  logic        w_h_wrap, w_v_wrap, w_h_vis, w_v_vis, w_h_sync, w_v_sync;

  assign w_h_wrap = (r_hcount == 11'(H_TOTAL - 1));
  assign w_v_wrap = (r_vcount == 11'(V_TOTAL - 1));
  assign w_h_vis  = ({1'b0, r_hcount} < 12'(H_ACTIVE));
  assign w_v_vis  = ({1'b0, r_vcount} < 12'(V_ACTIVE));
  assign w_h_sync = ({1'b0, r_hcount} >= 12'(H_SS)) && ({1'b0, r_hcount} < 12'(H_SE));
  assign w_v_sync = ({1'b0, r_vcount} >= 12'(V_SS)) && ({1'b0, r_vcount} < 12'(V_SE));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_hcount <= w_h_wrap ? 11'd0 : r_hcount + 11'd1;
      if (w_h_wrap)
        r_vcount <= w_v_wrap ? 11'd0 : r_vcount + 11'd1;
    end
  end

  // Controller-facing stage: registered snapshot of the counters.
  logic        r_hvis, r_vvis, r_hs, r_vs;
  logic [10:0] r_pos_x, r_pos_y;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hvis  <= 1'b0;
      r_vvis  <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      r_hvis  <= w_h_vis;
      r_vvis  <= w_v_vis;
      r_hs    <= w_h_sync;
      r_vs    <= w_v_sync;
      r_pos_x <= w_h_vis ? r_hcount : 11'd0;
      r_pos_y <= w_v_vis ? r_vcount : 11'd0;
    end
  end

  assign o_video_hblank = r_hvis;
  assign o_video_vblank = r_vvis;
  assign o_video_pos_x  = r_pos_x;
  assign o_video_pos_y  = r_pos_y;

  // Sync/DE travel alongside the controller's pixel pipeline so the tail lines up with i_video_rdata.
  tap_t [PIXEL_LATENCY-1:0] r_dly_pipe;
  tap_t                     w_tap_in, w_tail;

  assign w_tap_in = {r_hvis & r_vvis, r_hs, r_vs};
  assign w_tail   = r_dly_pipe[PIXEL_LATENCY-1];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dly_pipe <= '0;
    end else begin
      r_dly_pipe[0] <= w_tap_in;
      for (int i = 1; i < PIXEL_LATENCY; i++)
        r_dly_pipe[i] <= r_dly_pipe[i-1];
    end
  end

  logic        r_dvi_hsync, r_dvi_vsync, r_dvi_de;
  logic [23:0] r_dvi_rgb;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dvi_hsync <= ~H_SYNC_POL;
      r_dvi_vsync <= ~V_SYNC_POL;
      r_dvi_de    <= 1'b0;
      r_dvi_rgb   <= '0;
    end else begin
      r_dvi_hsync <= w_tail.hs ? H_SYNC_POL : ~H_SYNC_POL;
      r_dvi_vsync <= w_tail.vs ? V_SYNC_POL : ~V_SYNC_POL;
      r_dvi_de    <= w_tail.de;
      r_dvi_rgb   <= w_tail.de ? i_video_rdata[23:0] : 24'd0;
    end
  end

  assign o_dvi_hsync = r_dvi_hsync;
  assign o_dvi_vsync = r_dvi_vsync;
  assign o_dvi_de    = r_dvi_de;
  assign o_dvi_rgb   = r_dvi_rgb;

  logic w_unused_rdata;
  assign w_unused_rdata = ^i_video_rdata[31:24];

`ifdef VIDEO_TIMING_FRAME_IRQ_EN
  // Fires in the cycle o_video_vblank first drops, i.e. vcount has just reached V_ACTIVE.
  logic r_frame_irq;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_frame_irq <= 1'b0;
    else
      r_frame_irq <= (r_vcount == 11'(V_ACTIVE)) && (r_hcount == 11'd0);
  end

  assign o_frame_irq = r_frame_irq;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing with small timings (14x8 totals, latency 3), normal and inverted sync polarity.

module tb_video_timing;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  int          checks = 0;
  int          failures = 0;

  logic        hb, vb, hs, vs, de;
  logic [10:0] px, py;
  logic [23:0] rgb;
  logic [31:0] rdata;
  logic        hb_p, vb_p, hs_p, vs_p, de_p;
  logic [10:0] px_p, py_p;
  logic [23:0] rgb_p;
  logic [31:0] rdata_p;
  logic        irq, irq_p;

  logic [2:0][31:0] m_d, m_d_p;

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  video_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIXEL_LATENCY(3)
  ) dut (
    .i_clock(clk), .i_reset(i_reset),
    .o_video_hblank(hb), .o_video_vblank(vb),
    .o_video_pos_x(px), .o_video_pos_y(py),
    .i_video_rdata(rdata),
    .o_dvi_hsync(hs), .o_dvi_vsync(vs), .o_dvi_de(de), .o_dvi_rgb(rgb)
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    , .o_frame_irq(irq)
`endif
  );

  video_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIXEL_LATENCY(3)
  ) dut_p (
    .i_clock(clk), .i_reset(i_reset),
    .o_video_hblank(hb_p), .o_video_vblank(vb_p),
    .o_video_pos_x(px_p), .o_video_pos_y(py_p),
    .i_video_rdata(rdata_p),
    .o_dvi_hsync(hs_p), .o_dvi_vsync(vs_p), .o_dvi_de(de_p), .o_dvi_rgb(rgb_p)
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    , .o_frame_irq(irq_p)
`endif
  );

`ifndef VIDEO_TIMING_FRAME_IRQ_EN
  assign irq   = 1'b0;
  assign irq_p = 1'b0;
`endif

  // Controller model: pixel word for the position shown 3 clocks earlier.
  always @(posedge clk) begin
    m_d   <= {m_d[1:0],   {8'hAA, 2'b00, py,   px}};
    m_d_p <= {m_d_p[1:0], {8'hAA, 2'b00, py_p, px_p}};
  end
  assign rdata   = m_d[2];
  assign rdata_p = m_d_p[2];

  task automatic test_reset;
    int hc, c, ey, ex;
    logic ehb, ede;
    logic [23:0] ergb;
    i_reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if ({hb, vb, px, py} !== 24'd0) begin failures++; $display("FAIL reset_video got hb=%b vb=%b x=%0d y=%0d want all 0", hb, vb, px, py); end
    checks++; if ({de, rgb} !== 25'd0) begin failures++; $display("FAIL reset_dvi got de=%b rgb=%h want 0/0", de, rgb); end
    checks++; if ({hs, vs} !== 2'b11) begin failures++; $display("FAIL reset_sync got hs=%b vs=%b want 1/1", hs, vs); end
    checks++; if ({hs_p, vs_p} !== 2'b00) begin failures++; $display("FAIL reset_sync_pol got hs=%b vs=%b want 0/0", hs_p, vs_p); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", irq); end
    i_reset = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      c    = n - 1;
      hc   = c % 14;
      ehb  = (hc < 8);
      ex   = ehb ? hc : 0;
      ey   = c / 14;
      ede  = (n >= 5 && n <= 12);
      ergb = ede ? 24'(n - 5) : 24'd0;
      checks++; if (hb !== ehb || vb !== 1'b1) begin failures++; $display("FAIL release_blank n=%0d got hb=%b vb=%b want %b/1", n, hb, vb, ehb); end
      checks++; if (px !== 11'(ex) || py !== 11'(ey)) begin failures++; $display("FAIL release_pos n=%0d got (%0d,%0d) want (%0d,%0d)", n, px, py, ex, ey); end
      checks++; if (de !== ede || rgb !== ergb) begin failures++; $display("FAIL release_de n=%0d got de=%b rgb=%h want %b/%h", n, de, rgb, ede, ergb); end
    end
  endtask

  task automatic test_line_frame;
    int t_a[2];
    int na, w, i;
    logic prev, cur;
    // hsync: asserted low on dut
    na = 0; w = -1; prev = hs;
    for (i = 0; i < 60 && (na < 2 || w < 0); i++) begin
      @(negedge clk); cur = hs;
      if (prev && !cur) begin if (na < 2) t_a[na] = i; na++; end
      if (!prev && cur && na >= 1 && w < 0) w = i - t_a[0];
      prev = cur;
    end
    checks++;
    if (na < 2 || w < 0) begin failures++; $display("FAIL hsync_timeout got %0d pulses want 2", na); end
    else begin
      if (t_a[1] - t_a[0] != 14) begin failures++; $display("FAIL hsync_period got %0d want 14", t_a[1] - t_a[0]); end
      checks++; if (w != 3) begin failures++; $display("FAIL hsync_width got %0d want 3", w); end
    end
    na = 0; w = -1; prev = vs;
    for (i = 0; i < 300 && (na < 2 || w < 0); i++) begin
      @(negedge clk); cur = vs;
      if (prev && !cur) begin if (na < 2) t_a[na] = i; na++; end
      if (!prev && cur && na >= 1 && w < 0) w = i - t_a[0];
      prev = cur;
    end
    checks++;
    if (na < 2 || w < 0) begin failures++; $display("FAIL vsync_timeout got %0d pulses want 2", na); end
    else begin
      if (t_a[1] - t_a[0] != 112) begin failures++; $display("FAIL vsync_period got %0d want 112", t_a[1] - t_a[0]); end
      checks++; if (w != 28) begin failures++; $display("FAIL vsync_width got %0d want 28", w); end
    end
  endtask

  task automatic test_pixel_align;
    logic synced, prev_de, prev_vs;
    int line, xpos, decnt, frames;
    logic [23:0] e_rgb;
    synced = 1'b0; prev_de = de; prev_vs = vs;
    line = 0; xpos = 0; decnt = 0; frames = 0;
    for (int i = 0; i < 360; i++) begin
      @(negedge clk);
      if (!de) begin
        checks++; if (rgb !== 24'd0) begin failures++; $display("FAIL rgb_blank got %h want 0", rgb); end
      end
      if (!hb) begin
        checks++; if (px !== 11'd0) begin failures++; $display("FAIL pos_x_blank got %0d want 0", px); end
      end
      if (!vb) begin
        checks++; if (py !== 11'd0) begin failures++; $display("FAIL pos_y_blank got %0d want 0", py); end
      end
      if (prev_vs && !vs) begin
        if (synced) begin
          checks++; frames++;
          if (decnt != 32) begin failures++; $display("FAIL de_per_frame got %0d want 32", decnt); end
        end
        synced = 1'b1; line = 0; decnt = 0;
      end
      if (de && synced) begin
        e_rgb = {2'b00, 11'(line), 11'(xpos)};
        checks++; if (rgb !== e_rgb) begin failures++; $display("FAIL pixel_align got %h want %h", rgb, e_rgb); end
        xpos++; decnt++;
      end
      if (!de) xpos = 0;
      if (prev_de && !de) line++;
      prev_de = de; prev_vs = vs;
    end
    checks++; if (frames < 2) begin failures++; $display("FAIL frame_count got %0d want >=2", frames); end
  endtask

  task automatic test_polarity;
    int hcnt, vcnt, since_fall;
    logic prev_de, prev_hsp;
    hcnt = 0; vcnt = 0; since_fall = 100; prev_de = de_p; prev_hsp = hs_p;
    for (int i = 0; i < 112; i++) begin
      @(negedge clk);
      checks++; if (hs_p !== ~hs || vs_p !== ~vs) begin failures++; $display("FAIL pol_sync got %b%b want %b%b", hs_p, vs_p, ~hs, ~vs); end
      checks++; if (de_p !== de) begin failures++; $display("FAIL pol_de got %b want %b", de_p, de); end
      if (hs_p) hcnt++;
      if (vs_p) vcnt++;
      since_fall = (prev_de && !de_p) ? 0 : since_fall + 1;
      if (!prev_hsp && hs_p && since_fall < 14) begin
        checks++; if (since_fall != 2) begin failures++; $display("FAIL pol_hs_after_de got %0d want 2", since_fall); end
      end
      prev_de = de_p; prev_hsp = hs_p;
    end
    checks++; if (hcnt != 24) begin failures++; $display("FAIL pol_hs_high got %0d want 24", hcnt); end
    checks++; if (vcnt != 28) begin failures++; $display("FAIL pol_vs_high got %0d want 28", vcnt); end
  endtask

  task automatic test_mid_reset;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (hb && vb && px == 11'd5 && py == 11'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midreset_wait got no (5,2) want (5,2) within 300"); end
    i_reset = 1'b1;
    @(negedge clk);
    checks++; if ({hb, vb, de} !== 3'b000 || {hs, vs, hs_p, vs_p} !== 4'b1100) begin failures++; $display("FAIL midreset_values got hb=%b vb=%b de=%b sync=%b%b%b%b", hb, vb, de, hs, vs, hs_p, vs_p); end
    i_reset = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++; if ({hb, vb} !== 2'b11 || px !== 11'd0 || py !== 11'd0) begin failures++; $display("FAIL midreset_restart got hb=%b vb=%b (%0d,%0d) want 1/1 (0,0)", hb, vb, px, py); end
      end
      if (n <= 4) begin
        checks++; if (de !== 1'b0 || {hs, vs, hs_p, vs_p} !== 4'b1100) begin failures++; $display("FAIL midreset_flush n=%0d got de=%b sync=%b%b%b%b", n, de, hs, vs, hs_p, vs_p); end
      end else begin
        checks++; if (de !== 1'b1 || rgb !== 24'(n - 5)) begin failures++; $display("FAIL midreset_first_px n=%0d got de=%b rgb=%h want 1/%h", n, de, rgb, 24'(n - 5)); end
      end
    end
  endtask

`ifdef VIDEO_TIMING_FRAME_IRQ_EN
  task automatic test_irq;
    int pulses, falls;
    logic prev_vb, prev_irq;
    pulses = 0; falls = 0; prev_vb = vb; prev_irq = irq;
    for (int i = 0; i < 224; i++) begin
      @(negedge clk);
      if (prev_vb && !vb) falls++;
      if (irq) begin
        pulses++;
        checks++; if (!(prev_vb && !vb) || prev_irq) begin failures++; $display("FAIL irq_align got prev_vb=%b vb=%b prev_irq=%b want 1/0/0", prev_vb, vb, prev_irq); end
      end
      prev_vb = vb; prev_irq = irq;
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL irq_count got %0d want 2", pulses); end
    checks++; if (falls != 2) begin failures++; $display("FAIL vblank_falls got %0d want 2", falls); end
  endtask
`endif

  initial begin
    test_reset();
    test_line_frame();
    test_pixel_align();
    test_polarity();
    test_mid_reset();
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
